// File: rtl/delay_tap_reader_8x256_if.sv
// rtl/delay_tap_reader_8x256_if.sv - write/stream/tap-read bundle for the circular delay buffer
interface delay_tap_reader_8x256_if #(
    parameter int WIDTH = 8
);
    logic             shift;
    logic [WIDTH-1:0] sr_in;
    logic             flush;
    logic             delay_ld;
    logic [7:0]       delay_val;
    logic [WIDTH-1:0] sr_out;
    logic             out_valid;
    logic             rd_req;
    logic [7:0]       rd_tap;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [8:0]       fill;
    logic             running;

    modport master (
        output shift, sr_in, flush, delay_ld, delay_val, rd_req, rd_tap,
        input  sr_out, out_valid, rd_data, rd_valid, fill, running
    );

    modport slave (
        input  shift, sr_in, flush, delay_ld, delay_val, rd_req, rd_tap,
        output sr_out, out_valid, rd_data, rd_valid, fill, running
    );
endinterface

// File: rtl/delay_tap_reader_8x256.sv
// rtl/delay_tap_reader_8x256.sv - RAM circular delay buffer with streaming output and tap reads
module delay_tap_reader_8x256 #(
    parameter int DEPTH         = 256,
    parameter int WIDTH         = 8,
    parameter int DEFAULT_DELAY = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    delay_tap_reader_8x256_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW-1:0]    delay_q, delay_d;
    logic [WIDTH-1:0] sr_out_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    logic [FW-1:0]    fill_base;
    logic [PW-1:0]    stream_addr;
    logic             stream_bypass;
    logic             stream_fire;
    logic [PW-1:0]    tap_addr;
    logic             tap_hit;

    // Next pointer/fill/delay and the read addresses for both read ends.
    // The stream tap D-1 is taken in the post-shift view, so its address is
    // relative to the pre-shift write pointer: wr_ptr - (D-1). D=1 means the
    // sample being written this cycle, which is not in the RAM yet.
    always_comb begin
        fill_base     = bus.flush ? '0 : fill_q;
        fill_d        = fill_base;
        wr_ptr_d      = wr_ptr_q;
        delay_d       = bus.delay_ld ? (FW'(bus.delay_val) + FW'(1)) : delay_q;
        if (bus.shift) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (fill_base != FW'(DEPTH)) begin
                fill_d = fill_base + FW'(1);
            end
        end
        stream_fire   = bus.shift && (fill_d >= delay_d);
        stream_bypass = (delay_d == FW'(1));
        stream_addr   = wr_ptr_q - PW'(delay_d - FW'(1));
        tap_addr      = wr_ptr_q - PW'(1) - PW'(bus.rd_tap);
        tap_hit       = (FW'(bus.rd_tap) < fill_q);
    end

    // RUN exactly while enough history is held to serve the current delay.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (fill_d >= delay_d) state_d = ST_RUN;
            ST_RUN:  if (fill_d < delay_d)  state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // Sample storage; never reset, the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (bus.shift) begin
            mem[wr_ptr_q] <= bus.sr_in;
        end
    end

    // Control state and registered outputs. Tap reads see the RAM before
    // this cycle's write (read-first), which gives the pre-shift view.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            delay_q     <= FW'(DEFAULT_DELAY);
            sr_out_q    <= '0;
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            delay_q     <= delay_d;
            out_valid_q <= stream_fire;
            if (stream_fire) begin
                sr_out_q <= stream_bypass ? bus.sr_in : mem[stream_addr];
            end
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= tap_hit ? mem[tap_addr] : '0;
            end
        end
    end

    assign bus.sr_out    = sr_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.fill      = fill_q;
    assign bus.running   = (state_q == ST_RUN);
endmodule

// File: tb/tb_delay_tap_reader_8x256.sv
// tb/tb_delay_tap_reader_8x256.sv - randomized model-checked bench for delay_tap_reader_8x256
module tb_delay_tap_reader_8x256;
    logic clk = 1'b0;
    logic rst = 1'b1;

    delay_tap_reader_8x256_if #(.WIDTH(8)) bus ();

    delay_tap_reader_8x256 #(
        .DEPTH(256), .WIDTH(8), .DEFAULT_DELAY(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    // model: full sample history (newest first), valid-count and delay
    logic [7:0] hist[$];
    int         m_fill = 0;
    int         m_d    = 20;
    logic [7:0] exp_sr = 8'h00;
    bit         exp_ov = 1'b0;
    bit         exp_rv = 1'b0;
    logic [7:0] exp_rd = 8'h00;
    int         exp_fill = 0;
    bit         exp_run  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tot_cnt++;
        if (act !== req) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // drive one cycle, advance the model to what must appear after the edge
    task automatic step(input bit r, input bit sh, input logic [7:0] din, input bit fl,
                        input bit ld, input logic [7:0] dv, input bit rq, input logic [7:0] tp);
        rst           = r;
        bus.shift     = sh;
        bus.sr_in     = din;
        bus.flush     = fl;
        bus.delay_ld  = ld;
        bus.delay_val = dv;
        bus.rd_req    = rq;
        bus.rd_tap    = tp;
        if (r) begin
            m_fill = 0;
            m_d    = 20;
            exp_sr = 8'h00;
            exp_ov = 1'b0;
            exp_rv = 1'b0;
            exp_rd = 8'h00;
        end else begin
            exp_rv = rq;
            if (rq) exp_rd = (int'(tp) < m_fill) ? hist[tp] : 8'h00;
            if (ld) m_d = int'(dv) + 1;
            if (fl) m_fill = 0;
            if (sh) begin
                hist.push_front(din);
                if (hist.size() > 300) void'(hist.pop_back());
                if (m_fill < 256) m_fill++;
            end
            exp_ov = sh && (m_fill >= m_d);
            if (exp_ov) exp_sr = hist[m_d - 1];
        end
        exp_fill = m_fill;
        exp_run  = (m_fill >= m_d);
        chk_en   = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic shift_in(input logic [7:0] din);
        step(1'b0, 1'b1, din, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            check("sr_out", {24'd0, bus.sr_out}, {24'd0, exp_sr});
            check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, exp_rv});
            if (exp_rv) check("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_rd});
            check("fill", {23'd0, bus.fill}, 32'(exp_fill));
            check("running", {31'd0, bus.running}, {31'd0, exp_run});
        end
    end

    initial begin
        bus.shift = 0; bus.sr_in = 0; bus.flush = 0; bus.delay_ld = 0;
        bus.delay_val = 0; bus.rd_req = 0; bus.rd_tap = 0;

        // reset defaults
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("rst_fill", {23'd0, bus.fill}, 32'd0);
        check("rst_running", {31'd0, bus.running}, 32'd0);

        // default delay 20: first output after 20th shift equals 1
        for (int n = 1; n <= 25; n++) begin
            shift_in(8'(n));
            if (n == 19) check("t1_ov_n19", {31'd0, bus.out_valid}, 32'd0);
            if (n == 19) check("t1_run_n19", {31'd0, bus.running}, 32'd0);
            if (n == 20) check("t1_sr_n20", {24'd0, bus.sr_out}, 32'd1);
            if (n == 20) check("t1_run_n20", {31'd0, bus.running}, 32'd1);
            if (n == 25) check("t1_sr_n25", {24'd0, bus.sr_out}, 32'd6);
        end

        // D=1 bypass
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        check("t2_sr_bypass", {24'd0, bus.sr_out}, 32'hA5);
        check("t2_ov_bypass", {31'd0, bus.out_valid}, 32'd1);

        // wrap: 300 shifts of n mod 256
        for (int n = 0; n < 300; n++) shift_in(8'(n));
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
        check("t3_fill_sat", {23'd0, bus.fill}, 32'd256);
        check("t3_tap0", {24'd0, bus.rd_data}, 32'd43);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd255);
        check("t3_tap255", {24'd0, bus.rd_data}, 32'd44);

        // pre-shift tap view and unfilled tap
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) shift_in(8'(100 + i));
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd10);
        check("t4_tap10_empty", {24'd0, bus.rd_data}, 32'd0);
        step(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 8'h00, 1'b1, 8'd9);
        check("t4_tap9_preshift", {24'd0, bus.rd_data}, 32'd100);

        // flush+shift while running, then raise the delay above fill
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 25; i++) shift_in(8'($urandom));
        step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t5_flush_fill", {23'd0, bus.fill}, 32'd1);
        check("t5_flush_run", {31'd0, bus.running}, 32'd0);
        for (int i = 1; i <= 19; i++) begin
            shift_in(8'($urandom));
            if (i == 18) check("t5_ov_i18", {31'd0, bus.out_valid}, 32'd0);
            if (i == 19) check("t5_ov_i19", {31'd0, bus.out_valid}, 32'd1);
        end
        for (int i = 0; i < 10; i++) shift_in(8'($urandom));
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd49, 1'b0, 8'h00);
        check("t5_ld_run", {31'd0, bus.running}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            shift_in(8'($urandom));
            if (i == 19) check("t5_run_fill49", {31'd0, bus.running}, 32'd0);
            if (i == 20) check("t5_run_fill50", {31'd0, bus.running}, 32'd1);
        end

        // reset mid-stream with a read request
        step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 8'd3);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
        check("t6_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_sr_out", {24'd0, bus.sr_out}, 32'd0);
        check("t6_fill", {23'd0, bus.fill}, 32'd0);
        check("t6_rd_data", {24'd0, bus.rd_data}, 32'd0);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            bit         r, sh, fl, ld, rq;
            logic [7:0] dv, tp;
            r  = ($urandom % 600) == 0;
            sh = ($urandom % 4) != 0;
            fl = ($urandom % 70) == 0;
            ld = ($urandom % 40) == 0;
            dv = (($urandom % 3) == 0) ? 8'($urandom) : 8'($urandom % 32);
            rq = ($urandom % 2) == 1;
            tp = (($urandom % 2) == 0) ? 8'($urandom) : 8'($urandom % 40);
            step(r, sh, 8'($urandom), fl, ld, dv, rq, tp);
        end

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk_en = 1'b0;
        #20;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
